// File: rtl/ysyx_23060201_gpr_pkg.sv
`default_nettype none
// ============================================================================
// Module : ysyx_23060201_gpr_pkg
// Brief  : Shared widths, requester indices and counter limit for GPR writeback
// Rev    : 1.0  initial release
// ============================================================================
package ysyx_23060201_gpr_pkg;

    localparam int DEF_GPR_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_CNT_WIDTH      = 2;

    localparam logic REQ_EXU = 1'b0;
    localparam logic REQ_LSU = 1'b1;

    function automatic int cnt_max(input int width);
        return (1 << width) - 1;
    endfunction

    localparam int DEF_CNT_MAX = cnt_max(DEF_CNT_WIDTH);

endpackage
`default_nettype wire

// File: rtl/ysyx_23060201_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module : ysyx_23060201_rr_arb2
// Brief  : Two-input round-robin arbiter; grants are combinational from req/last
// Rev    : 1.0  initial release
// ============================================================================
module ysyx_23060201_rr_arb2
    import ysyx_23060201_gpr_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic r_last;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        gnt = 2'b00;
        if (req[REQ_EXU] && req[REQ_LSU]) begin
            if (r_last == REQ_LSU) gnt[REQ_EXU] = 1'b1;
            else                   gnt[REQ_LSU] = 1'b1;
        end else begin
            gnt = req;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= REQ_LSU;
        end else if (|gnt) begin
            r_last <= gnt[REQ_LSU];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_23060201_gpr_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module : ysyx_23060201_gpr_wb_ctrl
// Brief  : EXU/LSU writeback arbiter, registered GPR write port, RAW scoreboard
// Rev    : 1.0  initial release
// ============================================================================
module ysyx_23060201_gpr_wb_ctrl
    import ysyx_23060201_gpr_pkg::*;
#(
    parameter int GPR_ADDR_WIDTH = DEF_GPR_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      exu_valid,
    output logic                      exu_ready,
    input  logic [GPR_ADDR_WIDTH-1:0] exu_waddr,
    input  logic [DATA_WIDTH-1:0]     exu_wdata,
    input  logic                      lsu_valid,
    output logic                      lsu_ready,
    input  logic [GPR_ADDR_WIDTH-1:0] lsu_waddr,
    input  logic [DATA_WIDTH-1:0]     lsu_wdata,
    input  logic                      issue_valid,
    input  logic [GPR_ADDR_WIDTH-1:0] issue_rd,
    output logic                      issue_ready,
    input  logic [GPR_ADDR_WIDTH-1:0] chk_raddr1,
    input  logic [GPR_ADDR_WIDTH-1:0] chk_raddr2,
    output logic                      chk_busy1,
    output logic                      chk_busy2,
    output logic                      gpr_wen,
    output logic [GPR_ADDR_WIDTH-1:0] gpr_waddr,
    output logic [DATA_WIDTH-1:0]     gpr_wdata
);

    localparam int                   c_nreg    = 1 << GPR_ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

    logic [1:0]                w_gnt;
    logic                      w_xfer;
    logic [GPR_ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0]     w_wdata;
    logic [c_nreg-1:0]         w_inc;
    logic [c_nreg-1:0]         w_dec;

    logic                      r_wen;
    logic [GPR_ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [CNT_WIDTH-1:0]      r_cnt [c_nreg];

    ysyx_23060201_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({lsu_valid, exu_valid}),
        .gnt   (w_gnt)
    );

    assign exu_ready = w_gnt[REQ_EXU];
    assign lsu_ready = w_gnt[REQ_LSU];
    assign w_xfer    = |w_gnt;
    assign w_waddr   = w_gnt[REQ_LSU] ? lsu_waddr : exu_waddr;
    assign w_wdata   = w_gnt[REQ_LSU] ? lsu_wdata : exu_wdata;

    assign gpr_wen   = r_wen;
    assign gpr_waddr = r_waddr;
    assign gpr_wdata = r_wdata;

    // r_cnt[0] is held at zero, so x0 reads as never busy and always ready.
    assign issue_ready = (issue_rd == '0) || (r_cnt[issue_rd] != c_cnt_max);
    assign chk_busy1   = (r_cnt[chk_raddr1] != '0);
    assign chk_busy2   = (r_cnt[chk_raddr2] != '0);

    // A retire against an idle counter is a protocol error and is ignored.
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        if (issue_valid && issue_ready && (issue_rd != '0)) begin
            w_inc[issue_rd] = 1'b1;
        end
        if (r_wen && (r_cnt[r_waddr] != '0)) begin
            w_dec[r_waddr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            for (int i = 0; i < c_nreg; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_wen <= w_xfer && (w_waddr != '0);
            if (w_xfer) begin
                r_waddr <= w_waddr;
                r_wdata <= w_wdata;
            end
            r_cnt[0] <= '0;
            for (int i = 1; i < c_nreg; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
                end else if (w_dec[i] && !w_inc[i]) begin
                    r_cnt[i] <= r_cnt[i] - CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060201_gpr_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_ysyx_23060201_gpr_wb_ctrl
// Brief  : Directed bench with a cycle model of the writeback controller
// Rev    : 1.0  initial release
// ============================================================================
module tb_ysyx_23060201_gpr_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        exu_valid = 1'b0, lsu_valid = 1'b0, issue_valid = 1'b0;
    logic [4:0]  exu_waddr = '0, lsu_waddr = '0, issue_rd = '0;
    logic [4:0]  chk_raddr1 = '0, chk_raddr2 = '0;
    logic [31:0] exu_wdata = '0, lsu_wdata = '0;
    logic        exu_ready, lsu_ready, issue_ready, chk_busy1, chk_busy2, gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;

    int n_checks = 0;
    int n_errors = 0;

    ysyx_23060201_gpr_wb_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_waddr(exu_waddr), .exu_wdata(exu_wdata),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .chk_raddr1(chk_raddr1), .chk_raddr2(chk_raddr2),
        .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
        .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: pending counts, who won last, and the write presented to the GPR.
    int          m_cnt [32];
    int          m_last_lsu;
    bit          m_wen;
    int          m_waddr;
    logic [31:0] m_wdata;
    bit          m_init = 1'b0;

    always @(negedge clk) begin
        bit g_exu, g_lsu, ir, inc, dec;
        if (exu_valid && lsu_valid) begin
            g_exu = (m_last_lsu == 1);
            g_lsu = !g_exu;
        end else begin
            g_exu = exu_valid;
            g_lsu = lsu_valid;
        end
        ir = (issue_rd == 0) || (m_cnt[issue_rd] < 3);
        if (m_init) begin
            chk("exu_ready",   {31'b0, exu_ready},   {31'b0, g_exu});
            chk("lsu_ready",   {31'b0, lsu_ready},   {31'b0, g_lsu});
            chk("gpr_wen",     {31'b0, gpr_wen},     {31'b0, m_wen});
            chk("gpr_waddr",   {27'b0, gpr_waddr},   m_waddr);
            chk("gpr_wdata",   gpr_wdata,            m_wdata);
            chk("issue_ready", {31'b0, issue_ready}, {31'b0, ir});
            chk("chk_busy1",   {31'b0, chk_busy1},   {31'b0, m_cnt[chk_raddr1] > 0});
            chk("chk_busy2",   {31'b0, chk_busy2},   {31'b0, m_cnt[chk_raddr2] > 0});
        end
        // Advance the model to the state after the coming posedge.
        if (!rst_n) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_last_lsu = 1;
            m_wen = 0; m_waddr = 0; m_wdata = '0;
            m_init = 1'b1;
        end else if (m_init) begin
            inc = issue_valid && ir && (issue_rd != 0);
            dec = m_wen && (m_cnt[m_waddr] > 0);
            if (!(inc && dec && (issue_rd == m_waddr))) begin
                if (inc) m_cnt[issue_rd] = m_cnt[issue_rd] + 1;
                if (dec) m_cnt[m_waddr]  = m_cnt[m_waddr] - 1;
            end
            m_wen = 0;
            if (g_exu) begin
                m_waddr = exu_waddr; m_wdata = exu_wdata; m_wen = (exu_waddr != 0); m_last_lsu = 0;
            end else if (g_lsu) begin
                m_waddr = lsu_waddr; m_wdata = lsu_wdata; m_wen = (lsu_waddr != 0); m_last_lsu = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        chk("rst_wen",   {31'b0, gpr_wen}, 32'd0);
        chk("rst_waddr", {27'b0, gpr_waddr}, 32'd0);
        chk("rst_wdata", gpr_wdata, 32'd0);
        rst_n = 1'b1;

        // EXU-only write to x5.
        exu_valid = 1; exu_waddr = 5; exu_wdata = 32'h1234;
        #1 chk("t1_exu_ready", {31'b0, exu_ready}, 32'd1);
        tick(); exu_valid = 0;
        chk("t1_wen", {31'b0, gpr_wen}, 32'd1);
        chk("t1_waddr", {27'b0, gpr_waddr}, 32'd5);
        chk("t1_wdata", gpr_wdata, 32'h1234);
        tick();
        chk("t1_wen_drop", {31'b0, gpr_wen}, 32'd0);

        // Both requesters continuously valid; EXU won last, so LSU leads.
        exu_valid = 1; exu_waddr = 1; exu_wdata = 32'hAAAA_0001;
        lsu_valid = 1; lsu_waddr = 2; lsu_wdata = 32'hBBBB_0002;
        #1 chk("t2_lsu_first", {31'b0, lsu_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t2_wen", {31'b0, gpr_wen}, 32'd1);
            chk("t2_waddr", {27'b0, gpr_waddr}, (k % 2 == 0) ? 32'd2 : 32'd1);
        end
        exu_valid = 0; lsu_valid = 0;
        tick();

        // Issue rd=7, then LSU retires x7.
        issue_valid = 1; issue_rd = 7; chk_raddr1 = 7;
        tick(); issue_valid = 0;
        chk("t3_busy_set", {31'b0, chk_busy1}, 32'd1);
        lsu_valid = 1; lsu_waddr = 7; lsu_wdata = 32'h77;
        tick(); lsu_valid = 0;
        chk("t3_busy_hold", {31'b0, chk_busy1}, 32'd1);
        tick();
        chk("t3_busy_clr", {31'b0, chk_busy1}, 32'd0);

        // Issue and retire x3 in the same cycle keeps the count at 1.
        chk_raddr2 = 3;
        issue_valid = 1; issue_rd = 3;
        tick(); issue_valid = 0;
        exu_valid = 1; exu_waddr = 3; exu_wdata = 32'h33;
        tick(); exu_valid = 0;
        issue_valid = 1; issue_rd = 3;
        tick(); issue_valid = 0;
        chk("t4_busy_same", {31'b0, chk_busy2}, 32'd1);
        tick();
        chk("t4_busy_still", {31'b0, chk_busy2}, 32'd1);
        exu_valid = 1;
        tick(); exu_valid = 0;
        tick();
        chk("t4_busy_clr", {31'b0, chk_busy2}, 32'd0);

        // Saturate x9, then a write to x0.
        issue_valid = 1; issue_rd = 9;
        repeat (3) tick();
        #1 chk("t5_rd9_full", {31'b0, issue_ready}, 32'd0);
        tick();
        issue_rd = 10;
        #1 chk("t5_rd10_ready", {31'b0, issue_ready}, 32'd1);
        issue_valid = 0; issue_rd = 0;
        #1 chk("t5_x0_ready", {31'b0, issue_ready}, 32'd1);
        chk_raddr1 = 0; chk_raddr2 = 9;
        exu_valid = 1; exu_waddr = 0; exu_wdata = 32'hFFFF;
        tick(); exu_valid = 0;
        chk("t5_x0_wen", {31'b0, gpr_wen}, 32'd0);
        chk("t5_x0_busy", {31'b0, chk_busy1}, 32'd0);
        chk("t5_x9_busy", {31'b0, chk_busy2}, 32'd1);

        // Reset right after a transfer drops the in-flight write.
        exu_valid = 1; exu_waddr = 9; exu_wdata = 32'h99;
        tick(); exu_valid = 0;
        chk("t6_inflight", {31'b0, gpr_wen}, 32'd1);
        rst_n = 0;
        tick();
        chk("t6_rst_wen", {31'b0, gpr_wen}, 32'd0);
        chk("t6_rst_busy", {31'b0, chk_busy2}, 32'd0);
        rst_n = 1;
        exu_valid = 1; lsu_valid = 1; exu_waddr = 4; lsu_waddr = 6;
        #1 chk("t6_exu_tie", {31'b0, exu_ready}, 32'd1);
        tick(); exu_valid = 0; lsu_valid = 0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
